scv_cart: RTL and testbench
===========================

// Module: scv_cart
// PURPOSE
//  Cartridge-side responder for the Super Cassette Vision CPU bus: accepts a ROM image streamed in
//  by the loader, then answers uPD7800 reads/writes in the 8000h-FFFFh window from on-chip ROM/RAM.
//  Sits in scv beside cpu and video; the top muxes DB_O onto the CPU data bus when DB_OE=1.
// PARAMETERS
//  ROM_AW   17  ROM address width (128 KiB max image)
//  RAM_AW   13  cart SRAM address width (8 KiB, E000h-FFFFh)
// PORTS
//  CLK           in   1   system clock (2x 14.318181 MHz)
//  RESB          in   1   reset, asynchronous, active-low
//  LOAD_START    in   1   pulse: begin new image, clear byte count
//  LOAD_WR       in   1   pulse: LOAD_DATA valid, store at count, count++
//  LOAD_DATA     in   8   image byte
//  LOAD_DONE     in   1   pulse: image complete
//  LOAD_BUSY     out  1   1 while in LOADING
//  CART_PRESENT  out  1   1 while in READY
//  MAPPER        in   2   0 flat 32K, 1 banked, 2 flat+RAM, 3 banked+RAM
//  BANK_SEL      in   2   32 KiB bank select (CPU port C bits)
//  A             in   16  CPU address
//  DB_I          in   8   CPU write data
//  DB_O          out  8   read data
//  DB_OE         out  1   drive enable for DB_O
//  RDB, WRB      in   1   CPU read/write strobes, active-low
// BEHAVIOUR
//  Reset: state EMPTY, count 0, mask 0, LOAD_BUSY=0, CART_PRESENT=0, DB_O=00h, DB_OE=0. RAM contents undefined.
//  FSM: EMPTY/READY --LOAD_START--> LOADING; LOADING --LOAD_DONE--> READY if count>0 else EMPTY.
//   LOAD_START in LOADING restarts (count=0). Reset mid-load -> EMPTY, partial image discarded.
//  Load: LOAD_WR ignored outside LOADING. Write addr = count[ROM_AW-1:0]. Once count = 2^ROM_AW,
//   count saturates and further bytes are dropped.
//   LOAD_START+LOAD_WR same cycle: start wins, byte dropped. LOAD_DONE+LOAD_WR same cycle: byte stored
//   first and counted.
//  Mask: at LOAD_DONE, mask = (smallest 2^n >= count) - 1, minimum 1FFFh; held until next LOAD_START.
//  Decode (READY only, A[15]=1): bank = MAPPER[0] ? BANK_SEL : 0; rom_addr = {bank,A[14:0]} & mask.
//   MAPPER[1]=1 and A[15:13]=111b -> RAM at A[RAM_AW-1:0]; ROM not returned there.
//  Read: RDB sampled low with window hit -> DB_O valid and DB_OE=1 on the next CLK edge (latency 1).
//   Held while RDB low. DB_OE=0 the edge after RDB high, A[15]=0, or state != READY.
//   During EMPTY/LOADING, DB_OE=0 always (top supplies open-bus FFh).
//  Write: WRB falling edge (registered edge detect), RAM region -> one RAM write of DB_I.
//   WRB held low does not repeat the write. Writes to ROM region or outside READY are ignored.
//  RDB and WRB both low: write proceeds, DB_OE=0.
// STRUCTURE
//  scv_cart_pkg: mapper_t enum (MAP_FLAT, MAP_BANK, MAP_FLAT_RAM, MAP_BANK_RAM);
//   cart_state_t (ST_EMPTY, ST_LOADING, ST_READY); CART_BASE=16'h8000; RAM_BASE=16'hE000;
//   MIN_MASK=17'h1FFF.
//  Sub-module: dpram (existing). One instance for ROM (port A loader, port B CPU);
//   one instance for RAM (single-port use).
// TESTING
//  1 Load 32768 B, byte[i]=i[7:0]^i[15:8], MAPPER=0; read 8000h -> 00h, 8123h -> 22h.
//    DB_OE=1 only from 1 edge after RDB low until 1 edge after RDB high.
//  2 Load 8192 B same pattern; read A005h and E005h -> 05h (mirror, mask 1FFFh).
//  3 MAPPER=1, load 65536 B, BANK_SEL=1; read 8010h -> image[8010h]=90h.
//    BANK_SEL=0 -> 10h.
//  4 MAPPER=2; WRB pulse A=E010h DB_I=5Ah -> read E010h returns 5Ah.
//    WRB held 10 cycles -> exactly one RAM write. Write to 9000h leaves ROM unchanged.
//  5 Reset asserted after 100 bytes loaded -> LOAD_BUSY=0, CART_PRESENT=0, DB_OE=0.
//    Reads at 8000h never drive.
//  6 LOAD_START with LOAD_WR same cycle, then LOAD_DONE -> count 0, state EMPTY, CART_PRESENT=0.

Source files
------------

// File: rtl/scv_cart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scv_cart_pkg
//  Purpose  : Shared types and constants for the Super Cassette Vision
//             cartridge responder (mapper modes, cartridge states, window
//             base addresses, smallest ROM decode mask).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package scv_cart_pkg;

    // Cartridge mapper modes. Bit 0 enables 32 KiB banking and bit 1
    // enables the cart SRAM at E000h-FFFFh.
    typedef enum logic [1:0] {
        MAP_FLAT     = 2'd0,
        MAP_BANK     = 2'd1,
        MAP_FLAT_RAM = 2'd2,
        MAP_BANK_RAM = 2'd3
    } mapper_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } cart_state_t;

    localparam logic [15:0] CART_BASE = 16'h8000;
    localparam logic [15:0] RAM_BASE  = 16'hE000;
    localparam logic [16:0] MIN_MASK  = 17'h1FFF;

    function automatic logic mapper_banked(input mapper_t m);
        return (m == MAP_BANK) || (m == MAP_BANK_RAM);
    endfunction

    function automatic logic mapper_has_ram(input mapper_t m);
        return (m == MAP_FLAT_RAM) || (m == MAP_BANK_RAM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram.sv
`default_nettype none
// ============================================================================
//  Module   : dpram
//  Purpose  : Simple dual-port RAM, one write port and one synchronous read
//             port on a common clock. Read returns the old contents when the
//             same address is written in the same cycle. No reset on contents.
//  Ports    : clk      in  clock
//             we       in  write enable
//             wr_addr  in  write address  [AW-1:0]
//             wr_data  in  write data     [DW-1:0]
//             rd_addr  in  read address   [AW-1:0]
//             rd_data  out registered read data [DW-1:0]
//  Revision : 1.0  initial release
// ============================================================================
module dpram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/scv_cart.sv
`default_nettype none
// ============================================================================
//  Module   : scv_cart
//  Purpose  : Cartridge-side responder for the SCV CPU bus. Captures a ROM
//             image streamed in by the loader, then answers CPU reads and
//             writes in the 8000h-FFFFh window from on-chip ROM / cart SRAM.
//  Ports    : CLK, RESB (async active-low reset)
//             LOAD_START/LOAD_WR/LOAD_DATA/LOAD_DONE  loader stream in
//             LOAD_BUSY     out 1 while loading
//             CART_PRESENT  out 1 while an image is ready
//             MAPPER[1:0], BANK_SEL[1:0]  mapping controls
//             A[15:0], DB_I[7:0], RDB, WRB  CPU bus in (strobes active-low)
//             DB_O[7:0], DB_OE          read data and drive enable
//  Revision : 1.0  initial release
// ============================================================================
module scv_cart
    import scv_cart_pkg::*;
#(
    parameter int ROM_AW = 17,
    parameter int RAM_AW = 13
) (
    input  logic        CLK,
    input  logic        RESB,
    input  logic        LOAD_START,
    input  logic        LOAD_WR,
    input  logic [7:0]  LOAD_DATA,
    input  logic        LOAD_DONE,
    output logic        LOAD_BUSY,
    output logic        CART_PRESENT,
    input  logic [1:0]  MAPPER,
    input  logic [1:0]  BANK_SEL,
    input  logic [15:0] A,
    input  logic [7:0]  DB_I,
    output logic [7:0]  DB_O,
    output logic        DB_OE,
    input  logic        RDB,
    input  logic        WRB
);

    localparam logic [ROM_AW:0] C_CNT_ONE = {{ROM_AW{1'b0}}, 1'b1};

    cart_state_t       r_state, w_state_nxt;
    logic [ROM_AW:0]   r_count;
    logic [ROM_AW:0]   w_cnt_final;
    logic [ROM_AW-1:0] r_mask;
    logic [ROM_AW-1:0] w_new_mask;
    logic [ROM_AW-1:0] w_rom_raddr;
    logic              w_load_we;
    logic              w_busy, w_present;
    logic              r_wrb_d, r_oe, r_sel_ram;
    logic [7:0]        w_rom_q, w_ram_q;
    mapper_t           w_map;
    logic [1:0]        w_bank;
    logic              w_win, w_ram_region, w_rd_hit, w_ram_we;

    // Loader bytes are accepted only while loading, never on the cycle a
    // restart is requested, and never once the ROM is full (count MSB set).
    assign w_load_we   = (r_state == ST_LOADING) && LOAD_WR && !LOAD_START
                         && !r_count[ROM_AW];
    assign w_cnt_final = w_load_we ? (r_count + C_CNT_ONE) : r_count;

    // Decode mask: grow the minimum mask one bit at a time until it covers
    // the final byte count (the byte arriving with LOAD_DONE included).
    always_comb begin
        w_new_mask = ROM_AW'(MIN_MASK);
        for (int i = 0; i < ROM_AW; i++) begin
            if (({1'b0, w_new_mask} + C_CNT_ONE) < w_cnt_final) begin
                w_new_mask = {w_new_mask[ROM_AW-2:0], 1'b1};
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_present   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (LOAD_START) begin
                    w_state_nxt = ST_LOADING;
                end
            end
            ST_LOADING: begin
                w_busy = 1'b1;
                if (LOAD_START) begin
                    w_state_nxt = ST_LOADING;
                end else if (LOAD_DONE) begin
                    w_state_nxt = (w_cnt_final != '0) ? ST_READY : ST_EMPTY;
                end
            end
            ST_READY: begin
                w_present = 1'b1;
                if (LOAD_START) begin
                    w_state_nxt = ST_LOADING;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    assign LOAD_BUSY    = w_busy;
    assign CART_PRESENT = w_present;

    // ------------------------------------------------------ count and mask
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_count <= '0;
            r_mask  <= '0;
        end else begin
            if (LOAD_START) begin
                r_count <= '0;
                r_mask  <= '0;
            end else begin
                if (w_load_we) begin
                    r_count <= r_count + C_CNT_ONE;
                end
                if ((r_state == ST_LOADING) && LOAD_DONE) begin
                    r_mask <= w_new_mask;
                end
            end
        end
    end

    // ------------------------------------------------------------- decode
    assign w_map        = mapper_t'(MAPPER);
    assign w_bank       = mapper_banked(w_map) ? BANK_SEL : 2'b00;
    assign w_rom_raddr  = ROM_AW'({w_bank, A[14:0]}) & r_mask;
    assign w_win        = (r_state == ST_READY) && (A[15] == CART_BASE[15]);
    assign w_ram_region = mapper_has_ram(w_map) && (A[15:13] == RAM_BASE[15:13]);
    // A simultaneous write strobe suppresses the read drive.
    assign w_rd_hit     = w_win && !RDB && WRB;
    // One RAM write per WRB falling edge, however long WRB stays low.
    assign w_ram_we     = w_win && w_ram_region && r_wrb_d && !WRB;

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_wrb_d   <= 1'b1;
            r_oe      <= 1'b0;
            r_sel_ram <= 1'b0;
        end else begin
            r_wrb_d   <= WRB;
            r_oe      <= w_rd_hit;
            r_sel_ram <= w_ram_region;
        end
    end

    // Gating with the live state keeps the bus released on the very cycle
    // a reload begins, even if a read was registered just before it.
    assign DB_OE = r_oe && (r_state == ST_READY);
    assign DB_O  = DB_OE ? (r_sel_ram ? w_ram_q : w_rom_q) : 8'h00;

    // ------------------------------------------------------------ storage
    dpram #(
        .AW (ROM_AW),
        .DW (8)
    ) u_rom (
        .clk     (CLK),
        .we      (w_load_we),
        .wr_addr (r_count[ROM_AW-1:0]),
        .wr_data (LOAD_DATA),
        .rd_addr (w_rom_raddr),
        .rd_data (w_rom_q)
    );

    dpram #(
        .AW (RAM_AW),
        .DW (8)
    ) u_ram (
        .clk     (CLK),
        .we      (w_ram_we),
        .wr_addr (A[RAM_AW-1:0]),
        .wr_data (DB_I),
        .rd_addr (A[RAM_AW-1:0]),
        .rd_data (w_ram_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_scv_cart.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scv_cart
//  Purpose  : Self-checking bench for scv_cart. Table of read vectors per
//             loaded image plus hand-written write, reset and load-corner
//             sequences. Inputs change on the falling edge, outputs are
//             sampled on the following falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scv_cart;

    logic        CLK = 1'b0;
    logic        RESB;
    logic        LOAD_START, LOAD_WR, LOAD_DONE;
    logic [7:0]  LOAD_DATA;
    logic        LOAD_BUSY, CART_PRESENT;
    logic [1:0]  MAPPER, BANK_SEL;
    logic [15:0] A;
    logic [7:0]  DB_I, DB_O;
    logic        DB_OE, RDB, WRB;

    int checks   = 0;
    int failures = 0;

    scv_cart #(.ROM_AW(17), .RAM_AW(13)) dut (
        .CLK          (CLK),
        .RESB         (RESB),
        .LOAD_START   (LOAD_START),
        .LOAD_WR      (LOAD_WR),
        .LOAD_DATA    (LOAD_DATA),
        .LOAD_DONE    (LOAD_DONE),
        .LOAD_BUSY    (LOAD_BUSY),
        .CART_PRESENT (CART_PRESENT),
        .MAPPER       (MAPPER),
        .BANK_SEL     (BANK_SEL),
        .A            (A),
        .DB_I         (DB_I),
        .DB_O         (DB_O),
        .DB_OE        (DB_OE),
        .RDB          (RDB),
        .WRB          (WRB)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          ph;
        logic [1:0]  map;
        logic [1:0]  bank;
        logic [15:0] addr;
        logic        oe;
        logic [7:0]  data;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One read cycle: strobe for one edge, check drive and data, release.
    task automatic rd(input logic [15:0] a, input logic exp_oe, input logic [7:0] exp_d,
                      input string nm);
        A   = a;
        RDB = 1'b0;
        @(negedge CLK);
        chk({nm, " oe"}, {31'd0, DB_OE}, {31'd0, exp_oe});
        if (exp_oe) begin
            chk({nm, " data"}, {24'd0, DB_O}, {24'd0, exp_d});
        end
        RDB = 1'b1;
        @(negedge CLK);
        chk({nm, " release"}, {31'd0, DB_OE}, 32'd0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        A    = a;
        DB_I = d;
        WRB  = 1'b0;
        @(negedge CLK);
        WRB  = 1'b1;
        @(negedge CLK);
    endtask

    // Image pattern byte[i] = i[7:0] ^ i[15:8].
    task automatic load_image(input int n, input bit done_on_last, input string nm);
        @(negedge CLK);
        LOAD_START = 1'b1;
        @(negedge CLK);
        LOAD_START = 1'b0;
        chk({nm, " busy"}, {31'd0, LOAD_BUSY}, 32'd1);
        for (int i = 0; i < n; i++) begin
            LOAD_WR   = 1'b1;
            LOAD_DATA = i[7:0] ^ i[15:8];
            LOAD_DONE = done_on_last && (i == n - 1);
            @(negedge CLK);
        end
        LOAD_WR = 1'b0;
        if (!done_on_last) begin
            LOAD_DONE = 1'b1;
            @(negedge CLK);
        end
        LOAD_DONE = 1'b0;
        chk({nm, " present"}, {31'd0, CART_PRESENT}, 32'd1);
        chk({nm, " not busy"}, {31'd0, LOAD_BUSY}, 32'd0);
    endtask

    task automatic run_phase(input int p);
        for (int k = 0; k < NV; k++) begin
            if (vt[k].ph == p) begin
                MAPPER   = vt[k].map;
                BANK_SEL = vt[k].bank;
                rd(vt[k].addr, vt[k].oe, vt[k].data, $sformatf("vec%0d", k));
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // phase 1: 32 KiB flat image, mask 7FFFh
        vt[0]  = '{1, 2'd0, 2'd0, 16'h8000, 1'b1, 8'h00};
        vt[1]  = '{1, 2'd0, 2'd0, 16'h8123, 1'b1, 8'h22};
        vt[2]  = '{1, 2'd0, 2'd0, 16'hFFFF, 1'b1, 8'h80};
        vt[3]  = '{1, 2'd0, 2'd0, 16'hC000, 1'b1, 8'h40};
        vt[4]  = '{1, 2'd0, 2'd0, 16'h7FFF, 1'b0, 8'h00};
        vt[5]  = '{1, 2'd0, 2'd3, 16'h8123, 1'b1, 8'h22};
        // phase 2: 8 KiB image, mask 1FFFh mirrors
        vt[6]  = '{2, 2'd0, 2'd0, 16'hA005, 1'b1, 8'h05};
        vt[7]  = '{2, 2'd0, 2'd0, 16'hE005, 1'b1, 8'h05};
        vt[8]  = '{2, 2'd0, 2'd0, 16'h9FFF, 1'b1, 8'hE0};
        vt[9]  = '{2, 2'd0, 2'd0, 16'hBFFF, 1'b1, 8'hE0};
        vt[10] = '{2, 2'd0, 2'd0, 16'h8000, 1'b1, 8'h00};
        // phase 3: 32769 B banked image (last byte with LOAD_DONE), mask FFFFh
        vt[11] = '{3, 2'd1, 2'd1, 16'h8000, 1'b1, 8'h80};
        vt[12] = '{3, 2'd1, 2'd0, 16'h8000, 1'b1, 8'h00};
        vt[13] = '{3, 2'd1, 2'd0, 16'h8010, 1'b1, 8'h10};
        vt[14] = '{3, 2'd1, 2'd2, 16'h8010, 1'b1, 8'h10};
        vt[15] = '{3, 2'd1, 2'd3, 16'h8000, 1'b1, 8'h80};
        vt[16] = '{3, 2'd0, 2'd1, 16'h8000, 1'b1, 8'h00};
        vt[17] = '{3, 2'd1, 2'd1, 16'h4000, 1'b0, 8'h00};

        RESB = 1'b0; LOAD_START = 1'b0; LOAD_WR = 1'b0; LOAD_DONE = 1'b0;
        LOAD_DATA = 8'h00; MAPPER = 2'd0; BANK_SEL = 2'd0; A = 16'h0000;
        DB_I = 8'h00; RDB = 1'b1; WRB = 1'b1;

        repeat (3) @(negedge CLK);
        chk("reset busy", {31'd0, LOAD_BUSY}, 32'd0);
        chk("reset present", {31'd0, CART_PRESENT}, 32'd0);
        chk("reset oe", {31'd0, DB_OE}, 32'd0);
        chk("reset db_o", {24'd0, DB_O}, 32'd0);
        RESB = 1'b1;
        @(negedge CLK);
        rd(16'h8000, 1'b0, 8'h00, "empty read");

        // Test 1: read latency and release timing, then table
        load_image(32768, 1'b0, "img32k");
        MAPPER = 2'd0;
        A   = 16'h8123;
        RDB = 1'b0;
        #1 chk("t1 oe before edge", {31'd0, DB_OE}, 32'd0);
        @(negedge CLK);
        chk("t1 oe after edge", {31'd0, DB_OE}, 32'd1);
        chk("t1 data", {24'd0, DB_O}, 32'h22);
        @(negedge CLK);
        chk("t1 oe held", {31'd0, DB_OE}, 32'd1);
        RDB = 1'b1;
        #1 chk("t1 oe until edge", {31'd0, DB_OE}, 32'd1);
        @(negedge CLK);
        chk("t1 oe released", {31'd0, DB_OE}, 32'd0);
        run_phase(1);

        // Test 2
        load_image(8192, 1'b1, "img8k");
        run_phase(2);

        // Test 3: byte arriving with LOAD_DONE must widen the mask
        MAPPER = 2'd1;
        load_image(32769, 1'b1, "img32k1");
        run_phase(3);

        // Test 4: cart SRAM
        MAPPER = 2'd2; BANK_SEL = 2'd0;
        wr(16'hE010, 8'h5A);
        rd(16'hE010, 1'b1, 8'h5A, "ram 5a");
        A = 16'hE020; DB_I = 8'h11; WRB = 1'b0;
        @(negedge CLK);
        DB_I = 8'h22;
        repeat (9) @(negedge CLK);
        WRB = 1'b1;
        @(negedge CLK);
        rd(16'hE020, 1'b1, 8'h11, "ram held wrb");
        A = 16'hE030; DB_I = 8'h77; WRB = 1'b0; RDB = 1'b0;
        @(negedge CLK);
        chk("rd+wr oe", {31'd0, DB_OE}, 32'd0);
        @(negedge CLK);
        chk("rd+wr oe 2", {31'd0, DB_OE}, 32'd0);
        WRB = 1'b1; RDB = 1'b1;
        @(negedge CLK);
        rd(16'hE030, 1'b1, 8'h77, "rd+wr stored");
        wr(16'h9000, 8'hAA);
        rd(16'h9000, 1'b1, 8'h10, "rom unchanged");
        MAPPER = 2'd0;
        rd(16'hE010, 1'b1, 8'h70, "no ram in flat");
        MAPPER = 2'd3; BANK_SEL = 2'd1;
        rd(16'hE010, 1'b1, 8'h5A, "ram in bank+ram");

        // Test 5: reset mid-load
        @(negedge CLK);
        LOAD_START = 1'b1;
        @(negedge CLK);
        LOAD_START = 1'b0;
        for (int i = 0; i < 100; i++) begin
            LOAD_WR = 1'b1; LOAD_DATA = i[7:0];
            @(negedge CLK);
        end
        LOAD_WR = 1'b0;
        chk("t5 busy", {31'd0, LOAD_BUSY}, 32'd1);
        RESB = 1'b0;
        #1;
        chk("t5 busy rst", {31'd0, LOAD_BUSY}, 32'd0);
        chk("t5 present rst", {31'd0, CART_PRESENT}, 32'd0);
        chk("t5 oe rst", {31'd0, DB_OE}, 32'd0);
        @(negedge CLK);
        RESB = 1'b1;
        MAPPER = 2'd0; BANK_SEL = 2'd0;
        rd(16'h8000, 1'b0, 8'h00, "t5 read 8000");
        rd(16'h8123, 1'b0, 8'h00, "t5 read 8123");

        // Test 6: start wins over same-cycle write, done with zero bytes
        LOAD_START = 1'b1; LOAD_WR = 1'b1; LOAD_DATA = 8'h55;
        @(negedge CLK);
        LOAD_START = 1'b0; LOAD_WR = 1'b0;
        chk("t6 busy", {31'd0, LOAD_BUSY}, 32'd1);
        LOAD_DONE = 1'b1;
        @(negedge CLK);
        LOAD_DONE = 1'b0;
        chk("t6 busy after", {31'd0, LOAD_BUSY}, 32'd0);
        chk("t6 present", {31'd0, CART_PRESENT}, 32'd0);
        rd(16'h8000, 1'b0, 8'h00, "t6 read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
